multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multicycle variant of the RV32I core. One shared ALU, one unified instruction/data memory port, instruction register (IR), OldPC and ALUOut registers.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath enables and mux selects.
- Stalls on a memory ready handshake.

Parameters:
- MEM_WAIT_EN, 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  PC <= Result
- ir_write  out  1  IR, OldPC <= ReadData, PC
- adr_src  out  1  memory address: 0 = PC, 1 = Result
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- result_src  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U (combinational from op)
- state  out  4  current state, for debug/verification
- illegal_instr  out  1  one-cycle pulse on unknown op or unknown branch funct3

Behaviour:
- State register resets to FETCH (encoding 0) on the clock edge where reset = 1.
- While reset = 1, all enables and illegal_instr are forced to 0.
- Outputs are combinational from state plus the listed inputs. Any output not listed for a state is 0/00.

States:
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - mem_ready=0: hold all enables 0 and stay in FETCH.
- DECODE: a=01, b=01, alu_op=00, so ALUOut = OldPC + imm. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> ALUWB (AUIPC; ALUOut already holds the result)
  - any other op: illegal_instr=1, go to FETCH.
- MEMADR: a=10, b=01, alu_op=00. Load -> MEMREAD; store -> MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Stay until mem_ready, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, go to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Hold every cycle until mem_ready, then go to FETCH.
- EXECR: a=10, b=00, alu_op=10, go to ALUWB.
- EXECI: a=10, b=01, alu_op=10, go to ALUWB.
- LUI: a=11, b=01, alu_op=00, go to ALUWB.
- ALUWB: result_src=00, reg_write=1, go to FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, go to FETCH.
  - pc_write = taken, where taken is decoded by funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - funct3 010/011: taken=0 and illegal_instr=1.
- JAL: result_src=00, pc_write=1, go to LINK.
- JALR: a=10, b=01, alu_op=00, result_src=10, pc_write=1, go to LINK. The datapath clears bit 0 of the target.
- LINK: a=01, b=10, alu_op=00, result_src=10, reg_write=1, go to FETCH.

Rules and boundary conditions:
- imm_src decodes from op in every state. Unknown op gives 000.
- Cycles per instruction with mem_ready=1:
  - load 5
  - store 4
  - R/I/LUI 4
  - AUIPC 3
  - branch 3
  - JAL/JALR 4
- Reset mid-instruction: the next state is FETCH and no write enable asserts in the reset cycle.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.
- Unused state encodings recover to FETCH with no enables asserted.

Test Plan:
- reset=1 for 2 cycles while in MEMWRITE with mem_ready=0 -> state=0, mem_write=0 during reset; FETCH on the first cycle after release.
- ADD (op 0110011), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; reg_write=1 only in cycle 4 with result_src=00; alu_op=10 in EXECR.
- LW, mem_ready low for 3 cycles in MEMREAD -> FETCH, DECODE, MEMADR, MEMREAD×4, MEMWB; adr_src=1 throughout MEMREAD; reg_write with result_src=01 once.
- BNE with zero=1, then BLTU with ltu=1 -> pc_write=0 in the first BRANCH state and 1 in the second; each instruction returns to FETCH after 3 cycles.
- JALR -> pc_write=1 with result_src=10 in JALR; next cycle LINK with a=01, b=10, reg_write=1.
- op=1111111 -> illegal_instr high exactly one cycle in DECODE, no enables asserted, FETCH next; branch funct3=010 -> illegal_instr pulse, pc_write=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multicycle RV32I core.
// Steps fetch/decode/execute/memory/writeback and drives datapath controls.
//
// Ports:
//   clk, reset         core clock, synchronous active-high reset
//   op, funct3         opcode and funct3 fields of the IR
//   zero, lt, ltu      ALU flags used for branch resolution
//   mem_ready          memory access completes this cycle
//   pc_write, ir_write, mem_write, reg_write   datapath write enables
//   adr_src, alu_src_a, alu_src_b, alu_op,
//   result_src, imm_src                         datapath mux selects
//   state              current state (debug)
//   illegal_instr      one-cycle pulse on unknown op / branch funct3
module multicycle_control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] state,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_e state_q;
    state_e state_d;

    logic ready;
    logic taken;
    logic br_bad;

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch condition; 010/011 are not defined branch encodings.
    always_comb begin
        taken  = 1'b0;
        br_bad = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = lt;
            3'b101:  taken = ~lt;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: br_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: imm_src = 3'b000;
            OP_STORE:                   imm_src = 3'b001;
            OP_BRANCH:                  imm_src = 3'b010;
            OP_JAL:                     imm_src = 3'b011;
            OP_LUI, OP_AUIPC:           imm_src = 3'b100;
            default:                    imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_d       = S_FETCH;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        result_src    = 2'b00;
        illegal_instr = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    state_d  = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALUOut <= OldPC + imm, reused as branch/JAL target
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default: begin
                        illegal_instr = 1'b1;
                        state_d       = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_d   = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 2'b10;
                alu_op        = 2'b01;
                pc_write      = taken;
                illegal_instr = br_bad;
            end
            S_JAL: begin
                pc_write = 1'b1;
                state_d  = S_LINK;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = S_LINK;
            end
            S_LINK: begin
                // rd <= OldPC + 4
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        if (reset) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
            illegal_instr = 1'b0;
            state_d       = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm.
// Each task walks one instruction cycle by cycle against hand-built vectors.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [3:0] state;
    logic       illegal_instr;

    int checks = 0;
    int errors = 0;

    multicycle_control_fsm #(.MEM_WAIT_EN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct3       (funct3),
        .zero         (zero),
        .lt           (lt),
        .ltu          (ltu),
        .mem_ready    (mem_ready),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .adr_src      (adr_src),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .result_src   (result_src),
        .imm_src      (imm_src),
        .state        (state),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: state,pw,iw,as,mw,rw,a,b,aluop,rs,ill
    function automatic logic [17:0] obs();
        return {state, pc_write, ir_write, adr_src, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, illegal_instr};
    endfunction

    function automatic logic [17:0] ev(
        input logic [3:0] st,
        input logic pw, input logic iw, input logic as_,
        input logic mw, input logic rw,
        input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] ao, input logic [1:0] rs,
        input logic il);
        return {st, pw, iw, as_, mw, rw, a, b, ao, rs, il};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] e [8];
        logic        rdy [8];
        logic        rst [8];
        logic [17:0] o;
        op = 7'b0100011;
        funct3 = 3'b010;
        reset = 1'b1;
        mem_ready = 1'b0;
        tick();
        o = obs();
        checks++;
        if (o !== ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0)) begin
            errors++;
            $display("FAIL reset_init got %h want %h", o,
                     ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0));
        end
        reset = 1'b0;
        // store, stuck in MEMWRITE, then reset for 2 cycles
        rdy[0] = 1; rst[0] = 0; e[0] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        rdy[1] = 0; rst[1] = 0; e[1] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        rdy[2] = 0; rst[2] = 0; e[2] = ev(2,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0);
        rdy[3] = 0; rst[3] = 0; e[3] = ev(5,0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0);
        rdy[4] = 0; rst[4] = 0; e[4] = ev(5,0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0);
        rdy[5] = 0; rst[5] = 1; e[5] = ev(5,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0);
        rdy[6] = 1; rst[6] = 1; e[6] = ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        rdy[7] = 0; rst[7] = 0; e[7] = ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            reset = rst[i];
            #1;
            o = obs();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL reset cyc %0d got %h want %h", i, o, e[i]);
            end
            tick();
        end
    endtask

    task automatic test_add();
        logic [17:0] e [5];
        logic [17:0] o;
        op = 7'b0110011;
        funct3 = 3'b000;
        mem_ready = 1'b1;
        e[0] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        e[1] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        e[2] = ev(6,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0);
        e[3] = ev(8,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
        e[4] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        for (int i = 0; i < 5; i++) begin
            #1;
            o = obs();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL add cyc %0d got %h want %h", i, o, e[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_lw();
        logic [17:0] e [9];
        logic        rdy [9];
        logic [17:0] o;
        op = 7'b0000011;
        // starts in FETCH from the previous task
        rdy[0] = 0; e[0] = ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        rdy[1] = 1; e[1] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        rdy[2] = 0; e[2] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        rdy[3] = 0; e[3] = ev(2,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0);
        rdy[4] = 0; e[4] = ev(3,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0);
        rdy[5] = 0; e[5] = ev(3,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0);
        rdy[6] = 0; e[6] = ev(3,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0);
        rdy[7] = 1; e[7] = ev(3,0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0);
        rdy[8] = 0; e[8] = ev(4,0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,0);
        for (int i = 0; i < 9; i++) begin
            mem_ready = rdy[i];
            #1;
            o = obs();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL lw cyc %0d got %h want %h", i, o, e[i]);
            end
            tick();
        end
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL lw_end state got %0d want 0", state);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_branch();
        logic [17:0] e [6];
        logic [2:0]  f3 [6];
        logic [17:0] o;
        op = 7'b1100011;
        mem_ready = 1'b1;
        zero = 1'b1;
        lt = 1'b0;
        ltu = 1'b1;
        f3[0] = 3'b001; e[0] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        f3[1] = 3'b001; e[1] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        f3[2] = 3'b001; e[2] = ev(9,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,0);
        f3[3] = 3'b110; e[3] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        f3[4] = 3'b110; e[4] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        f3[5] = 3'b110; e[5] = ev(9,1,0,0,0,0,2'b10,2'b00,2'b01,2'b00,0);
        for (int i = 0; i < 6; i++) begin
            funct3 = f3[i];
            #1;
            o = obs();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL branch cyc %0d got %h want %h", i, o, e[i]);
            end
            tick();
        end
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL branch_end state got %0d want 0", state);
        end
        zero = 1'b0;
        ltu = 1'b0;
    endtask

    task automatic test_jalr();
        logic [17:0] e [5];
        logic [17:0] o;
        op = 7'b1100111;
        funct3 = 3'b000;
        mem_ready = 1'b1;
        e[0] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        e[1] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        e[2] = ev(11,1,0,0,0,0,2'b10,2'b01,2'b00,2'b10,0);
        e[3] = ev(12,0,0,0,0,1,2'b01,2'b10,2'b00,2'b10,0);
        e[4] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        for (int i = 0; i < 5; i++) begin
            #1;
            o = obs();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL jalr cyc %0d got %h want %h", i, o, e[i]);
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_auipc();
        logic [17:0] e [4];
        logic [17:0] o;
        op = 7'b0010111;
        mem_ready = 1'b1;
        e[0] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        e[1] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        e[2] = ev(8,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0);
        e[3] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        for (int i = 0; i < 4; i++) begin
            #1;
            o = obs();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL auipc cyc %0d got %h want %h", i, o, e[i]);
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_illegal();
        logic [17:0] e [7];
        logic [6:0]  ops [7];
        logic [17:0] o;
        mem_ready = 1'b1;
        funct3 = 3'b010;
        zero = 1'b1;
        ops[0] = 7'b1111111; e[0] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        ops[1] = 7'b1111111; e[1] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,1);
        ops[2] = 7'b1100011; e[2] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        ops[3] = 7'b1100011; e[3] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        ops[4] = 7'b1100011; e[4] = ev(9,0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,1);
        ops[5] = 7'b0110011; e[5] = ev(0,1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,0);
        ops[6] = 7'b0110011; e[6] = ev(1,0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0);
        for (int i = 0; i < 7; i++) begin
            op = ops[i];
            #1;
            o = obs();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL illegal cyc %0d got %h want %h", i, o, e[i]);
            end
            tick();
        end
        zero = 1'b0;
    endtask

    task automatic test_imm_src();
        logic [6:0] ops [10];
        logic [2:0] ei  [10];
        ops[0] = 7'b0000011; ei[0] = 3'b000;
        ops[1] = 7'b0010011; ei[1] = 3'b000;
        ops[2] = 7'b1100111; ei[2] = 3'b000;
        ops[3] = 7'b0100011; ei[3] = 3'b001;
        ops[4] = 7'b1100011; ei[4] = 3'b010;
        ops[5] = 7'b1101111; ei[5] = 3'b011;
        ops[6] = 7'b0110111; ei[6] = 3'b100;
        ops[7] = 7'b0010111; ei[7] = 3'b100;
        ops[8] = 7'b0110011; ei[8] = 3'b000;
        ops[9] = 7'b1111111; ei[9] = 3'b000;
        for (int i = 0; i < 10; i++) begin
            op = ops[i];
            #1;
            checks++;
            if (imm_src !== ei[i]) begin
                errors++;
                $display("FAIL imm_src op %b got %b want %b",
                         ops[i], imm_src, ei[i]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        op = 7'b0;
        funct3 = 3'b0;
        zero = 1'b0;
        lt = 1'b0;
        ltu = 1'b0;
        mem_ready = 1'b0;
        #2;
        test_reset();
        test_add();
        test_lw();
        test_branch();
        test_jalr();
        test_auipc();
        test_illegal();
        test_imm_src();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
